// File: rtl/mram_spi_responder.sv
// SPI slave stand-in for the MR25H128 MRAM: WREN/WRDI/RDSR/WRSR/READ/WRITE on a small
// emulated array whose contents (and SRWD/BP) survive reset, so pulse-ID restore can be exercised.
module mram_spi_responder #(
  parameter int MEM_BYTES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_sck,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic [7:0]  o_statusReg,
  output logic        o_wrStrobe,
  output logic [15:0] o_wrAddr,
  output logic [7:0]  o_wrData,
  output logic        o_cmdError
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // cs powers up deasserted so the first sampled edge is never a false fall
  logic [SYNC_STAGES-1:0] r_csSync = '1;
  logic [SYNC_STAGES-1:0] r_sckSync = '0;
  logic [SYNC_STAGES-1:0] r_mosiSync = '0;
  logic                   r_csPrev = 1'b1;
  logic                   r_sckPrev = 1'b0;

  // Non-volatile contents: zero only at power-up, never touched by reset
  logic [7:0] r_mem [MEM_BYTES] = '{default: 8'h00};
  logic       r_srwd = 1'b0;
  logic [1:0] r_bp = 2'b00;

  logic [2:0]  r_bitCnt;
  logic [6:0]  r_shift;
  logic [15:0] r_addr;
  logic        r_isRead;
  logic        r_wel;
  logic        r_miso;
  logic [6:0]  r_tx;
  logic        r_wrStrobe;
  logic [15:0] r_wrAddr;
  logic [7:0]  r_wrData;
  logic        r_cmdError;

  logic          w_cs;
  logic          w_sck;
  logic          w_mosi;
  logic          w_sckRise;
  logic          w_sckFall;
  logic          w_csFall;
  logic          w_byteDone;
  logic [7:0]    w_byteIn;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_status;
  logic [7:0]    w_loadByte;
  logic          w_protected;
  logic          w_setWel;
  logic          w_clrWel;
  logic          w_cmdErr;
  logic          w_wrCommit;
  logic          w_wrsrCommit;
  logic          w_addrInc;
  logic          w_txActive;

  always_ff @(posedge clk) begin
    r_csSync   <= {r_csSync[SYNC_STAGES-2:0], i_cs};
    r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], i_sck};
    r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
    r_csPrev   <= w_cs;
    r_sckPrev  <= w_sck;
  end

  assign w_cs       = r_csSync[SYNC_STAGES-1];
  assign w_sck      = r_sckSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_sckRise  = w_sck & ~r_sckPrev;
  assign w_sckFall  = ~w_sck & r_sckPrev;
  assign w_csFall   = ~w_cs & r_csPrev;
  assign w_byteIn   = {r_shift, w_mosi};
  assign w_byteDone = w_sckRise && (r_bitCnt == 3'd7) && !w_cs;
  assign w_idx      = r_addr[AW-1:0];
  assign w_status   = {r_srwd, 3'b000, r_bp, r_wel, 1'b0};
  assign w_loadByte = (r_state == RDSR) ? w_status : r_mem[w_idx];

  always_comb begin
    w_protected = 1'b0;
    case (r_bp)
      2'b01:   w_protected = &w_idx[AW-1:AW-2];
      2'b10:   w_protected = w_idx[AW-1];
      2'b11:   w_protected = 1'b1;
      default: w_protected = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // A high cs wins over everything, including a byte completing on the same cycle
  always_comb begin
    w_nextState = r_state;
    if (w_cs) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_csFall) w_nextState = CMD;
        CMD: begin
          if (w_byteDone) begin
            case (w_byteIn)
              8'h05:        w_nextState = RDSR;
              8'h01:        w_nextState = WRSR;
              8'h03, 8'h02: w_nextState = ADDR_HI;
              default:      w_nextState = IGNORE;
            endcase
          end
        end
        ADDR_HI: if (w_byteDone) w_nextState = ADDR_LO;
        ADDR_LO: if (w_byteDone) w_nextState = r_isRead ? RD_DATA : WR_DATA;
        WRSR:    if (w_byteDone) w_nextState = IGNORE;
        default: w_nextState = r_state;
      endcase
    end
  end

  always_comb begin
    w_setWel     = 1'b0;
    w_clrWel     = 1'b0;
    w_cmdErr     = 1'b0;
    w_wrCommit   = 1'b0;
    w_wrsrCommit = 1'b0;
    w_addrInc    = 1'b0;
    w_txActive   = 1'b0;
    case (r_state)
      CMD: begin
        if (w_byteDone) begin
          case (w_byteIn)
            8'h06:                      w_setWel = 1'b1;
            8'h04:                      w_clrWel = 1'b1;
            8'h05, 8'h01, 8'h03, 8'h02: w_cmdErr = 1'b0;
            default:                    w_cmdErr = 1'b1;
          endcase
        end
      end
      WR_DATA: begin
        w_addrInc  = w_byteDone;
        w_wrCommit = w_byteDone && r_wel && !w_protected;
      end
      RD_DATA: begin
        w_addrInc  = w_byteDone;
        w_txActive = 1'b1;
      end
      RDSR:    w_txActive = 1'b1;
      WRSR:    w_wrsrCommit = w_byteDone && r_wel;
      default: w_txActive = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wrCommit) r_mem[w_idx] <= w_byteIn;
    if (w_wrsrCommit) begin
      r_srwd <= w_byteIn[7];
      r_bp   <= w_byteIn[3:2];
    end
  end

  // Bit counting, address tracking and the miso shifter; a bit-count of zero on an sck fall
  // marks a byte boundary where the next outgoing byte is loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitCnt   <= 3'd0;
      r_shift    <= 7'd0;
      r_addr     <= 16'd0;
      r_isRead   <= 1'b0;
      r_wel      <= 1'b0;
      r_miso     <= 1'b0;
      r_tx       <= 7'd0;
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= 16'd0;
      r_wrData   <= 8'd0;
      r_cmdError <= 1'b0;
    end else begin
      if (r_state == IDLE)  r_bitCnt <= 3'd0;
      else if (w_sckRise)   r_bitCnt <= r_bitCnt + 3'd1;
      if (w_sckRise) r_shift <= w_byteIn[6:0];
      if (r_state == CMD && w_byteDone) r_isRead <= (w_byteIn == 8'h03);
      if (r_state == ADDR_HI && w_byteDone)      r_addr <= {w_byteIn, 8'h00} & ADDR_MASK;
      else if (r_state == ADDR_LO && w_byteDone) r_addr <= {r_addr[15:8], w_byteIn} & ADDR_MASK;
      else if (w_addrInc)                        r_addr <= (r_addr + 16'd1) & ADDR_MASK;
      if (w_setWel)      r_wel <= 1'b1;
      else if (w_clrWel) r_wel <= 1'b0;
      if (!w_txActive || w_cs) begin
        r_miso <= 1'b0;
        r_tx   <= 7'd0;
      end else if (w_sckFall) begin
        if (r_bitCnt == 3'd0) begin
          r_miso <= w_loadByte[7];
          r_tx   <= w_loadByte[6:0];
        end else begin
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[5:0], 1'b0};
        end
      end
      r_wrStrobe <= w_wrCommit;
      if (w_wrCommit) begin
        r_wrAddr <= r_addr;
        r_wrData <= w_byteIn;
      end
      r_cmdError <= w_cmdErr;
    end
  end

  assign o_miso      = r_miso;
  assign o_statusReg = w_status;
  assign o_wrStrobe  = r_wrStrobe;
  assign o_wrAddr    = r_wrAddr;
  assign o_wrData    = r_wrData;
  assign o_cmdError  = r_cmdError;

endmodule

// File: tb/tb_mram_spi_responder.sv
// Bench for mram_spi_responder: drives SPI mode-0 frames at clk/12 and scores
// committed writes and read-back bytes against queued expectations.
module tb_mram_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [7:0]  statusReg;
  logic        wrStrobe;
  logic [15:0] wrAddr;
  logic [7:0]  wrData;
  logic        cmdError;

  int testsRun = 0;
  int testsFailed = 0;

  logic [23:0] expWrQ[$];
  logic [7:0]  expRdQ[$];
  logic [15:0] obsAddr [64];
  logic [7:0]  obsData [64];
  int          obsCount = 0;
  int          obsIdx = 0;
  int          errCount = 0;
  logic [7:0]  rdBuf [16];
  logic [7:0]  wrBuf [16];

  mram_spi_responder #(.MEM_BYTES(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i_cs(cs), .i_sck(sck), .i_mosi(mosi),
    .o_miso(miso), .o_statusReg(statusReg), .o_wrStrobe(wrStrobe),
    .o_wrAddr(wrAddr), .o_wrData(wrData), .o_cmdError(cmdError)
  );

  always #5 clk = ~clk;

  // Captures every committed write and error pulse for the tests to score
  always @(negedge clk) begin
    if (wrStrobe && obsCount < 64) begin
      obsAddr[obsCount] = wrAddr;
      obsData[obsCount] = wrData;
      obsCount++;
    end
    if (cmdError) errCount++;
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (6) @(negedge clk);
      rx[i] = miso;
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_begin();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_cmd(input logic [7:0] op, input logic [7:0] arg, input bit hasArg);
    logic [7:0] rx;
    spi_begin();
    spi_byte(op, rx);
    if (hasArg) spi_byte(arg, rx);
    spi_end();
  endtask

  task automatic spi_read(input logic [15:0] addr, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_byte(8'h03, rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int i = 0; i < n; i++) spi_byte(8'h00, rdBuf[i]);
    spi_end();
  endtask

  task automatic spi_write(input logic [15:0] addr, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_byte(8'h02, rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int i = 0; i < n; i++) spi_byte(wrBuf[i], rx);
    spi_end();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (statusReg !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_status got=%h want=00", statusReg); end
    testsRun++;
    if (miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_miso got=%b want=0", miso); end
    testsRun++;
    if (wrStrobe !== 1'b0 || cmdError !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_strobes got=%b%b want=00", wrStrobe, cmdError);
    end
  endtask

  task automatic test_boot();
    logic [7:0] rx;
    logic [7:0] e;
    spi_cmd(8'h06, 8'h00, 1'b0);
    testsRun++;
    if (statusReg !== 8'h02) begin testsFailed++; $display("[TB] FAIL boot_wren got=%h want=02", statusReg); end
    spi_cmd(8'h01, 8'h02, 1'b1);
    testsRun++;
    if (statusReg !== 8'h02) begin testsFailed++; $display("[TB] FAIL boot_wrsr got=%h want=02", statusReg); end
    spi_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 2; i++) begin
      expRdQ.push_back(8'h02);
      spi_byte(8'h00, rx);
      e = expRdQ.pop_front();
      testsRun++;
      if (rx !== e) begin testsFailed++; $display("[TB] FAIL boot_rdsr[%0d] got=%h want=%h", i, rx, e); end
    end
    spi_end();
  endtask

  task automatic test_write_read();
    logic [7:0] pat [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [23:0] e;
    logic [7:0] eb;
    for (int i = 0; i < 8; i++) begin
      wrBuf[i] = pat[i];
      expWrQ.push_back({16'(i), pat[i]});
    end
    spi_write(16'h0000, 8);
    while (obsIdx < obsCount) begin
      testsRun++;
      if (expWrQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL t2_write extra addr=%h data=%h want=none", obsAddr[obsIdx], obsData[obsIdx]);
      end else begin
        e = expWrQ.pop_front();
        if ({obsAddr[obsIdx], obsData[obsIdx]} !== e) begin
          testsFailed++; $display("[TB] FAIL t2_write got=%h%h want=%h", obsAddr[obsIdx], obsData[obsIdx], e);
        end
      end
      obsIdx++;
    end
    testsRun++;
    if (expWrQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL t2_write_count missing=%0d want=0", expWrQ.size()); expWrQ.delete();
    end
    for (int i = 0; i < 8; i++) expRdQ.push_back(pat[i]);
    spi_read(16'h0000, 8);
    for (int i = 0; i < 8; i++) begin
      eb = expRdQ.pop_front();
      testsRun++;
      if (rdBuf[i] !== eb) begin testsFailed++; $display("[TB] FAIL t2_read[%0d] got=%h want=%h", i, rdBuf[i], eb); end
    end
  endtask

  task automatic test_reset_persist();
    logic [7:0] pat [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] eb;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (statusReg !== 8'h00) begin testsFailed++; $display("[TB] FAIL t5_wel got=%h want=00", statusReg); end
    for (int i = 0; i < 8; i++) expRdQ.push_back(pat[i]);
    spi_read(16'h0000, 8);
    for (int i = 0; i < 8; i++) begin
      eb = expRdQ.pop_front();
      testsRun++;
      if (rdBuf[i] !== eb) begin testsFailed++; $display("[TB] FAIL t5_read[%0d] got=%h want=%h", i, rdBuf[i], eb); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h06, 4, rx);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spi_byte(8'h06, rx);
    spi_end();
    testsRun++;
    if (statusReg !== 8'h00) begin testsFailed++; $display("[TB] FAIL midreset_ignored got=%h want=00", statusReg); end
    spi_cmd(8'h06, 8'h00, 1'b0);
    testsRun++;
    if (statusReg !== 8'h02) begin testsFailed++; $display("[TB] FAIL midreset_fresh got=%h want=02", statusReg); end
  endtask

  task automatic test_protect();
    logic [23:0] e;
    spi_cmd(8'h04, 8'h00, 1'b0);
    testsRun++;
    if (statusReg !== 8'h00) begin testsFailed++; $display("[TB] FAIL t3_wrdi got=%h want=00", statusReg); end
    wrBuf[0] = 8'hFF;
    spi_write(16'h0000, 1);
    testsRun++;
    if (obsCount !== obsIdx) begin testsFailed++; $display("[TB] FAIL t3a_nostrobe got=%0d want=0", obsCount - obsIdx); end
    obsIdx = obsCount;
    spi_cmd(8'h06, 8'h00, 1'b0);
    spi_cmd(8'h01, 8'h0E, 1'b1);
    testsRun++;
    if (statusReg !== 8'h0E) begin testsFailed++; $display("[TB] FAIL t3_bp11 got=%h want=0e", statusReg); end
    spi_write(16'h0000, 1);
    testsRun++;
    if (obsCount !== obsIdx) begin testsFailed++; $display("[TB] FAIL t3b_nostrobe got=%0d want=0", obsCount - obsIdx); end
    obsIdx = obsCount;
    spi_read(16'h0000, 1);
    testsRun++;
    if (rdBuf[0] !== 8'h01) begin testsFailed++; $display("[TB] FAIL t3_array got=%h want=01", rdBuf[0]); end
    // BP=01 guards only the top quarter: address 11 commits, 12 is dropped
    spi_cmd(8'h01, 8'h06, 1'b1);
    testsRun++;
    if (statusReg !== 8'h06) begin testsFailed++; $display("[TB] FAIL t3_bp01 got=%h want=06", statusReg); end
    wrBuf[0] = 8'h5A;
    wrBuf[1] = 8'h5B;
    expWrQ.push_back({16'h000B, 8'h5A});
    spi_write(16'h000B, 2);
    while (obsIdx < obsCount) begin
      testsRun++;
      if (expWrQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL t3c_write extra addr=%h data=%h want=none", obsAddr[obsIdx], obsData[obsIdx]);
      end else begin
        e = expWrQ.pop_front();
        if ({obsAddr[obsIdx], obsData[obsIdx]} !== e) begin
          testsFailed++; $display("[TB] FAIL t3c_write got=%h%h want=%h", obsAddr[obsIdx], obsData[obsIdx], e);
        end
      end
      obsIdx++;
    end
    testsRun++;
    if (expWrQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL t3c_write_count missing=%0d want=0", expWrQ.size()); expWrQ.delete();
    end
    spi_cmd(8'h01, 8'h00, 1'b1);
    testsRun++;
    if (statusReg !== 8'h02) begin testsFailed++; $display("[TB] FAIL t3_bp00 got=%h want=02", statusReg); end
  endtask

  task automatic test_wrap_abort();
    logic [23:0] e;
    logic [7:0] eb;
    logic [7:0] rx;
    wrBuf[0] = 8'hAA;
    wrBuf[1] = 8'hBB;
    expWrQ.push_back({16'h000F, 8'hAA});
    expWrQ.push_back({16'h0000, 8'hBB});
    spi_write(16'h000F, 2);
    while (obsIdx < obsCount) begin
      testsRun++;
      if (expWrQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL t4_write extra addr=%h data=%h want=none", obsAddr[obsIdx], obsData[obsIdx]);
      end else begin
        e = expWrQ.pop_front();
        if ({obsAddr[obsIdx], obsData[obsIdx]} !== e) begin
          testsFailed++; $display("[TB] FAIL t4_write got=%h%h want=%h", obsAddr[obsIdx], obsData[obsIdx], e);
        end
      end
      obsIdx++;
    end
    testsRun++;
    if (expWrQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL t4_write_count missing=%0d want=0", expWrQ.size()); expWrQ.delete();
    end
    expRdQ.push_back(8'hAA);
    expRdQ.push_back(8'hBB);
    spi_read(16'h000F, 2);
    for (int i = 0; i < 2; i++) begin
      eb = expRdQ.pop_front();
      testsRun++;
      if (rdBuf[i] !== eb) begin testsFailed++; $display("[TB] FAIL t4_read[%0d] got=%h want=%h", i, rdBuf[i], eb); end
    end
    spi_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_bits(8'h11, 5, rx);
    spi_end();
    testsRun++;
    if (obsCount !== obsIdx) begin testsFailed++; $display("[TB] FAIL t4_abort_strobe got=%0d want=0", obsCount - obsIdx); end
    obsIdx = obsCount;
    spi_read(16'h0000, 1);
    testsRun++;
    if (rdBuf[0] !== 8'hBB) begin testsFailed++; $display("[TB] FAIL t4_abort_array got=%h want=bb", rdBuf[0]); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    int errBefore;
    errBefore = errCount;
    spi_begin();
    spi_byte(8'h9F, rx);
    testsRun++;
    if (rx !== 8'h00) begin testsFailed++; $display("[TB] FAIL t6_miso_cmd got=%h want=00", rx); end
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'hFF, rx);
      testsRun++;
      if (rx !== 8'h00) begin testsFailed++; $display("[TB] FAIL t6_miso_ignore[%0d] got=%h want=00", i, rx); end
    end
    spi_end();
    testsRun++;
    if (errCount - errBefore !== 1) begin
      testsFailed++; $display("[TB] FAIL t6_cmd_error got=%0d want=1", errCount - errBefore);
    end
    testsRun++;
    if (miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL t6_miso_idle got=%b want=0", miso); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_write_read();
    test_reset_persist();
    test_reset_midframe();
    test_protect();
    test_wrap_abort();
    test_bad_opcode();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
